// File: rtl/game_object_ctrl.sv
// game_object_ctrl: per-frame Flappy Bird state engine.
// Owns bird physics, two scrolling pipe pairs, collision and score, and
// drives the sprite renderer's top-left corners (1=bird, 2/3=upper pipe A/B,
// 4/5=lower pipe A/B). Positions advance only on frame_tick (vblank start).
//
// Handshake: there is no valid/ready pair; frame_tick is a single-cycle
// strobe consumed in the cycle it is high, flap is a level whose rising edge
// is the only event of interest, and every output is a register that is
// valid in every cycle after reset.
module game_object_ctrl #(
  parameter logic [10:0] BIRD_X    = 11'd128,
  parameter logic [10:0] BIRD_W    = 11'd64,
  parameter logic [10:0] BIRD_H    = 11'd64,
  parameter logic [10:0] PIPE_W    = 11'd128,
  parameter logic [10:0] PIPE_H    = 11'd256,
  parameter logic [10:0] START_Y   = 11'd200,
  parameter logic [10:0] FLOOR_Y   = 11'd416,
  parameter logic [10:0] GAP       = 11'd128,
  parameter logic [10:0] GAP_MIN   = 11'd256,
  parameter logic [10:0] SPEED     = 11'd4,
  parameter logic [10:0] WRAP_SPAN = 11'd768,
  parameter logic [10:0] PIPE_A_X0 = 11'd640,
  parameter logic [10:0] PIPE_B_X0 = 11'd1024,
  parameter logic [10:0] GAP_TOP0  = 11'd288,
  parameter logic [7:0]  FLAP_V    = 8'd8,
  parameter logic [7:0]  GRAVITY   = 8'd1,
  parameter logic [7:0]  MAX_FALL  = 8'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        flap,
  output logic [10:0] posx1,
  output logic [10:0] posy1,
  output logic [10:0] posx2,
  output logic [10:0] posy2,
  output logic [10:0] posx3,
  output logic [10:0] posy3,
  output logic [10:0] posx4,
  output logic [10:0] posy4,
  output logic [10:0] posx5,
  output logic [10:0] posy5,
  output logic [7:0]  score,
  output logic        game_over,
  output logic        playing,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  // Two's complement upward velocity applied by a flap.
  localparam logic [7:0] VEL_FLAP = ~FLAP_V + 8'd1;

  state_t      state, n_state;
  logic [15:0] lfsr;
  logic        flap_prev;
  logic        flap_pending, n_pending;
  logic [10:0] bird_y, n_bird_y;
  logic [7:0]  vel, n_vel;            // signed, two's complement
  logic [10:0] x_a, x_b, n_x_a, n_x_b;
  logic [10:0] gap_a, gap_b, n_gap_a, n_gap_b;
  logic        passed_a, passed_b, n_passed_a, n_passed_b;
  logic [7:0]  score_q, n_score;

  logic        flap_edge;
  logic        eff_flap;
  logic [8:0]  vel_inc;
  logic [7:0]  vel_new;
  logic [11:0] y_sum;
  logic [10:0] gap_sample;
  logic        hit_a, hit_b, floor_hit, pass_a, pass_b;

  // Pipe scrolls left; once it would leave the screen it reappears one span to the right.
  function automatic logic [10:0] pipe_step(input logic [10:0] x);
    if (x < SPEED) return x - SPEED + WRAP_SPAN;
    return x - SPEED;
  endfunction

  function automatic logic h_overlap(input logic [10:0] x);
    return ({1'b0, x} < ({1'b0, BIRD_X} + {1'b0, BIRD_W})) &&
           (({1'b0, x} + {1'b0, PIPE_W}) > {1'b0, BIRD_X});
  endfunction

  function automatic logic v_hit(input logic [10:0] y, input logic [10:0] gt);
    return (y < gt) || (({1'b0, y} + {1'b0, BIRD_H}) > ({1'b0, gt} + {1'b0, GAP}));
  endfunction

  function automatic logic passed_bird(input logic [10:0] x);
    return ({1'b0, x} + {1'b0, PIPE_W}) <= {1'b0, BIRD_X};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  assign flap_edge  = flap & ~flap_prev;
  // A flap edge arriving together with the tick is applied on that tick.
  assign eff_flap   = flap_pending | flap_edge;
  assign vel_inc    = {vel[7], vel} + {1'b0, GRAVITY};
  assign vel_new    = eff_flap ? VEL_FLAP :
                      ($signed(vel_inc) > $signed({1'b0, MAX_FALL})) ? MAX_FALL : vel_inc[7:0];
  assign y_sum      = {1'b0, bird_y} + {{4{vel_new[7]}}, vel_new};
  assign gap_sample = GAP_MIN + {5'd0, lfsr[5:0]};

  // Collision and scoring look at the registered positions, i.e. one cycle after the update.
  assign hit_a     = h_overlap(x_a) && v_hit(bird_y, gap_a);
  assign hit_b     = h_overlap(x_b) && v_hit(bird_y, gap_b);
  assign floor_hit = bird_y >= FLOOR_Y;
  assign pass_a    = passed_bird(x_a) && !passed_a;
  assign pass_b    = passed_bird(x_b) && !passed_b;

  assign dbg_state = state;

  // Next-state logic: frame update on tick, otherwise collision/score evaluation.
  always_comb begin
    n_state    = state;
    n_pending  = flap_pending;
    n_bird_y   = bird_y;
    n_vel      = vel;
    n_x_a      = x_a;
    n_x_b      = x_b;
    n_gap_a    = gap_a;
    n_gap_b    = gap_b;
    n_passed_a = passed_a;
    n_passed_b = passed_b;
    n_score    = score_q;
    unique case (state)
      IDLE: begin
        // The starting flap only launches the game; it does not kick the bird.
        n_pending = 1'b0;
        if (flap_edge) n_state = PLAY;
      end
      PLAY: begin
        if (frame_tick) begin
          n_pending = 1'b0;
          n_vel     = vel_new;
          if (y_sum[11]) begin
            n_bird_y = 11'd0;
            n_vel    = 8'd0;
          end else if (y_sum[10:0] >= FLOOR_Y) begin
            n_bird_y = FLOOR_Y;
          end else begin
            n_bird_y = y_sum[10:0];
          end
          n_x_a = pipe_step(x_a);
          n_x_b = pipe_step(x_b);
          if (x_a < SPEED) begin
            n_gap_a    = gap_sample;
            n_passed_a = 1'b0;
          end
          if (x_b < SPEED) begin
            n_gap_b    = gap_sample;
            n_passed_b = 1'b0;
          end
        end else begin
          n_pending = flap_pending | flap_edge;
          if (hit_a || hit_b || floor_hit) n_state = DEAD;
          if (pass_a) begin
            n_passed_a = 1'b1;
            n_score    = sat_inc(n_score);
          end
          if (pass_b) begin
            n_passed_b = 1'b1;
            n_score    = sat_inc(n_score);
          end
        end
      end
      DEAD: begin
        n_pending = 1'b0;
        if (flap_edge) begin
          n_state    = IDLE;
          n_bird_y   = START_Y;
          n_vel      = 8'd0;
          n_x_a      = PIPE_A_X0;
          n_x_b      = PIPE_B_X0;
          n_gap_a    = GAP_TOP0;
          n_gap_b    = GAP_TOP0;
          n_passed_a = 1'b0;
          n_passed_b = 1'b0;
          n_score    = 8'd0;
        end
      end
      default: n_state = IDLE;
    endcase
  end

  // State, LFSR and registered sprite outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    flap_prev <= flap;
    if (rst) begin
      lfsr         <= 16'hACE1;
      state        <= IDLE;
      flap_pending <= 1'b0;
      bird_y       <= START_Y;
      vel          <= 8'd0;
      x_a          <= PIPE_A_X0;
      x_b          <= PIPE_B_X0;
      gap_a        <= GAP_TOP0;
      gap_b        <= GAP_TOP0;
      passed_a     <= 1'b0;
      passed_b     <= 1'b0;
      score_q      <= 8'd0;
      posx1        <= BIRD_X;
      posy1        <= START_Y;
      posx2        <= PIPE_A_X0;
      posx4        <= PIPE_A_X0;
      posx3        <= PIPE_B_X0;
      posx5        <= PIPE_B_X0;
      posy2        <= GAP_TOP0 - PIPE_H;
      posy3        <= GAP_TOP0 - PIPE_H;
      posy4        <= GAP_TOP0 + GAP;
      posy5        <= GAP_TOP0 + GAP;
      score        <= 8'd0;
      game_over    <= 1'b0;
      playing      <= 1'b0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      state        <= n_state;
      flap_pending <= n_pending;
      bird_y       <= n_bird_y;
      vel          <= n_vel;
      x_a          <= n_x_a;
      x_b          <= n_x_b;
      gap_a        <= n_gap_a;
      gap_b        <= n_gap_b;
      passed_a     <= n_passed_a;
      passed_b     <= n_passed_b;
      score_q      <= n_score;
      posx1        <= BIRD_X;
      posy1        <= n_bird_y;
      posx2        <= n_x_a;
      posx4        <= n_x_a;
      posx3        <= n_x_b;
      posx5        <= n_x_b;
      posy2        <= n_gap_a - PIPE_H;
      posy3        <= n_gap_b - PIPE_H;
      posy4        <= n_gap_a + GAP;
      posy5        <= n_gap_b + GAP;
      score        <= n_score;
      game_over    <= (n_state == DEAD);
      playing      <= (n_state == PLAY);
    end
  end

endmodule

// File: tb/tb_game_object_ctrl.sv
// Testbench for game_object_ctrl: directed scenarios, expectations queued
// against a target cycle and checked by an independent monitor.
module tb_game_object_ctrl;

  logic        clk = 1'b0;
  logic        rst, frame_tick, flap;
  logic [10:0] posx1, posy1, posx2, posy2, posx3, posy3, posx4, posy4, posx5, posy5;
  logic [7:0]  score;
  logic        game_over, playing;
  logic [1:0]  dbg_state;

  localparam logic [7:0] F_PX1 = 0, F_PY1 = 1, F_PX2 = 2, F_PY2 = 3, F_PX3 = 4,
                         F_PY3 = 5, F_PX4 = 6, F_PY4 = 7, F_PX5 = 8, F_PY5 = 9,
                         F_SCORE = 10, F_OVER = 11, F_PLAY = 12;

  game_object_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap(flap),
    .posx1(posx1), .posy1(posy1), .posx2(posx2), .posy2(posy2),
    .posx3(posx3), .posy3(posy3), .posx4(posx4), .posy4(posy4),
    .posx5(posx5), .posy5(posy5), .score(score), .game_over(game_over),
    .playing(playing), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Golden LFSR: 16-bit Fibonacci, taps 16,14,13,11, seeded on rst.
  logic [15:0] lfsr_m;
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  // Scoreboard: {target cycle[55:24], field id[23:16], expected value[15:0]}
  logic [55:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [15:0] field_val(input logic [7:0] id);
    case (id)
      F_PX1:   return {5'd0, posx1};
      F_PY1:   return {5'd0, posy1};
      F_PX2:   return {5'd0, posx2};
      F_PY2:   return {5'd0, posy2};
      F_PX3:   return {5'd0, posx3};
      F_PY3:   return {5'd0, posy3};
      F_PX4:   return {5'd0, posx4};
      F_PY4:   return {5'd0, posy4};
      F_PX5:   return {5'd0, posx5};
      F_PY5:   return {5'd0, posy5};
      F_SCORE: return {8'd0, score};
      F_OVER:  return {15'd0, game_over};
      F_PLAY:  return {15'd0, playing};
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic string field_name(input logic [7:0] id);
    case (id)
      F_PX1:   return "posx1";
      F_PY1:   return "posy1";
      F_PX2:   return "posx2";
      F_PY2:   return "posy2";
      F_PX3:   return "posx3";
      F_PY3:   return "posy3";
      F_PX4:   return "posx4";
      F_PY4:   return "posy4";
      F_PX5:   return "posx5";
      F_PY5:   return "posy5";
      F_SCORE: return "score";
      F_OVER:  return "game_over";
      F_PLAY:  return "playing";
      default: return "unknown";
    endcase
  endfunction

  // Expect field id to read val after off more rising edges.
  task automatic expect_at(input int off, input logic [7:0] id, input int val);
    exp_q.push_back({32'(cyc_cnt + off), id, 16'(val)});
  endtask

  // Monitor: just after each rising edge, compare every entry due this cycle.
  initial begin
    logic [55:0] keep[$];
    logic [15:0] act;
    forever begin
      @(posedge clk);
      #1;
      keep.delete();
      for (int i = 0; i < exp_q.size(); i++) begin
        if (int'(exp_q[i][55:24]) == cyc_cnt) begin
          n_cmp++;
          act = field_val(exp_q[i][23:16]);
          if (act !== exp_q[i][15:0]) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     field_name(exp_q[i][23:16]), act, exp_q[i][15:0], cyc_cnt);
          end
        end else if (int'(exp_q[i][55:24]) < cyc_cnt) begin
          n_cmp++;
          n_err++;
          $display("FAIL %s: check for cycle %0d was never evaluated",
                   field_name(exp_q[i][23:16]), exp_q[i][55:24]);
        end else begin
          keep.push_back(exp_q[i]);
        end
      end
      exp_q = keep;
    end
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic press();
    flap = 1'b1;
    step();
    flap = 1'b0;
    step();
  endtask

  task automatic expect_idle(input int off);
    expect_at(off, F_PX1, 128);
    expect_at(off, F_PY1, 200);
    expect_at(off, F_PX2, 640);
    expect_at(off, F_PX3, 1024);
    expect_at(off, F_PY2, 32);
    expect_at(off, F_PY4, 416);
    expect_at(off, F_SCORE, 0);
    expect_at(off, F_OVER, 0);
    expect_at(off, F_PLAY, 0);
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    if (chk) begin
      expect_idle(1);
      expect_at(1, F_PY3, 32);
      expect_at(1, F_PY5, 416);
      expect_at(1, F_PX4, 640);
      expect_at(1, F_PX5, 1024);
    end
    step();
  endtask

  initial begin
    int y, v, g, g2;
    rst = 1'b1;
    frame_tick = 1'b0;
    flap = 1'b0;

    // Reset values, idle ticks leave everything unchanged
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      expect_at(1, F_PY1, 200);
      expect_at(1, F_PX2, 640);
      expect_at(1, F_PLAY, 0);
      tick();
    end

    // Flap physics
    do_reset(0);
    expect_at(1, F_PLAY, 1);
    expect_at(1, F_PY1, 200);
    press();
    press();
    expect_at(1, F_PY1, 192);
    expect_at(1, F_PLAY, 1);
    tick();
    expect_at(1, F_PY1, 185);
    tick();
    expect_at(1, F_PY1, 179);
    tick();
    flap = 1'b1;
    frame_tick = 1'b1;
    expect_at(1, F_PY1, 171);
    step();
    flap = 1'b0;
    frame_tick = 1'b0;
    step();
    expect_at(1, F_PY1, 164);
    expect_at(1, F_PX2, 620);
    expect_at(1, F_PX4, 620);
    expect_at(1, F_PX3, 1004);
    tick();

    // Pipe wrap and gap resampling from the LFSR
    do_reset(0);
    press();
    dut.x_a = 11'd2;
    g = 256 + int'(lfsr_m[5:0]);
    expect_at(1, F_PX2, 766);
    expect_at(1, F_PX4, 766);
    expect_at(1, F_PY2, g - 256);
    expect_at(1, F_PY4, g + 128);
    expect_at(1, F_PY3, 32);
    expect_at(1, F_PX3, 1020);
    expect_at(1, F_PY1, 201);
    tick();
    dut.x_b = 11'd0;
    g2 = 256 + int'(lfsr_m[5:0]);
    expect_at(1, F_PX2, 762);
    expect_at(1, F_PX3, 764);
    expect_at(1, F_PY3, g2 - 256);
    expect_at(1, F_PY5, g2 + 128);
    expect_at(1, F_PY2, g - 256);
    expect_at(1, F_PY1, 203);
    tick();

    // Fall to the floor, freeze in DEAD, flap back to IDLE
    do_reset(0);
    press();
    y = 200;
    v = 0;
    for (int i = 1; i <= 27; i++) begin
      v = (v + 1 > 10) ? 10 : v + 1;
      y = (y + v >= 416) ? 416 : y + v;
      expect_at(1, F_PY1, y);
      if (i == 26) expect_at(1, F_PY1, 415);
      if (i == 27) begin
        expect_at(1, F_PY1, 416);
        expect_at(1, F_OVER, 0);
        expect_at(1, F_PLAY, 1);
        expect_at(2, F_OVER, 1);
        expect_at(2, F_PLAY, 0);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      expect_at(1, F_PY1, 416);
      expect_at(1, F_PX2, 532);
      expect_at(1, F_OVER, 1);
      tick();
    end
    expect_idle(1);
    press();

    // Score once per pass, then saturation at 255
    do_reset(0);
    press();
    dut.x_a = 11'd4;
    expect_at(1, F_PX2, 0);
    expect_at(1, F_SCORE, 0);
    expect_at(2, F_SCORE, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_at(1, F_SCORE, 1);
      step();
    end
    expect_at(1, F_PX2, 764);
    expect_at(1, F_SCORE, 1);
    expect_at(2, F_SCORE, 1);
    tick();
    dut.score_q = 8'd255;
    dut.x_a = 11'd4;
    expect_at(1, F_PX2, 0);
    expect_at(1, F_SCORE, 255);
    expect_at(2, F_SCORE, 255);
    tick();
    expect_at(1, F_SCORE, 255);
    expect_at(1, F_PLAY, 1);
    step();

    // Pipe collision, DEAD one cycle after the tick
    do_reset(0);
    press();
    dut.x_a = 11'd154;
    dut.gap_a = 11'd300;
    dut.bird_y = 11'd250;
    dut.vel = 8'hFF;
    expect_at(1, F_PX2, 150);
    expect_at(1, F_PY2, 44);
    expect_at(1, F_PY4, 428);
    expect_at(1, F_PY1, 250);
    expect_at(1, F_OVER, 0);
    expect_at(1, F_PLAY, 1);
    expect_at(2, F_OVER, 1);
    expect_at(2, F_PLAY, 0);
    tick();
    expect_at(1, F_PX2, 150);
    expect_at(1, F_PY1, 250);
    expect_at(1, F_OVER, 1);
    tick();

    // rst in the middle of PLAY
    do_reset(0);
    press();
    expect_at(1, F_PY1, 201);
    tick();
    expect_at(1, F_PY1, 203);
    expect_at(1, F_PX2, 632);
    tick();
    rst = 1'b1;
    expect_idle(1);
    step();
    rst = 1'b0;
    step();

    // Drain and report
    step();
    step();
    step();
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: check for cycle %0d still pending at end",
               field_name(exp_q[0][23:16]), exp_q[0][55:24]);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
